// File: rtl/fir_coef_bank.sv
// ---------------------------------------------------------------------------
// fir_coef_bank
//
// Double-buffered coefficient store for the FIR filter. TAPS words are
// streamed into a shadow bank over a valid/ready handshake. The complete
// shadow bank is then copied into the active bank in a single edge, gated by
// swap_en. Because of this, the filter never sees a partially updated set.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous, active-high reset
//   load_start - pulse; begins or restarts a load
//   coef_valid - coefficient word present on coef_data
//   coef_data  - coefficient word (DATA_WIDTH)
//   coef_ready - block accepts a word this cycle (registered)
//   swap_en    - permits the shadow-to-active swap
//   w_N        - active bank, word k at w_N[k*DATA_WIDTH +: DATA_WIDTH]
//   busy       - FSM not idle (registered)
//   load_done  - pulse; the new bank is visible on w_N this cycle
//   load_abort - pulse; an in-progress load was discarded
//
// Optional feature, enabled by defining FIR_COEF_READBACK_EN:
//   rd_addr    - active-bank read address
//   rd_data    - active[rd_addr], registered with 1-cycle latency;
//                an out-of-range address reads 0
// ---------------------------------------------------------------------------
module fir_coef_bank #(
    parameter int  TAPS       = 4,
    parameter int  DATA_WIDTH = 16,
    localparam int IDX_W      = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef FIR_COEF_READBACK_EN
    input  logic [IDX_W-1:0]           rd_addr,
    output logic [DATA_WIDTH-1:0]      rd_data,
`endif
    input  logic                       load_start,
    input  logic                       coef_valid,
    input  logic [DATA_WIDTH-1:0]      coef_data,
    output logic                       coef_ready,
    input  logic                       swap_en,
    output logic [TAPS*DATA_WIDTH-1:0] w_N,
    output logic                       busy,
    output logic                       load_done,
    output logic                       load_abort
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PEND = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [DATA_WIDTH-1:0]   shadow_q [TAPS];
    logic [DATA_WIDTH-1:0]   active_q [TAPS];

    logic                    coef_ready_q;
    logic                    coef_ready_d;
    logic                    busy_q;
    logic                    busy_d;
    logic                    load_done_q;
    logic                    load_done_d;
    logic                    load_abort_q;
    logic                    load_abort_d;

    logic                    hs_s;
    logic                    swap_s;

    // load_start has priority over both a handshake and a swap in the same cycle
    assign hs_s   = (state_q == S_LOAD) && coef_valid && !load_start;
    assign swap_s = (state_q == S_PEND) && swap_en && !load_start;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and write-index logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (load_start) begin
            state_d = S_LOAD;
            idx_d   = {IDX_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_LOAD: begin
                    if (coef_valid) begin
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_d = S_PEND;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        idx_d = idx_q;
                    end
                end
                S_PEND: begin
                    if (swap_en) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PEND;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output next values; derived from state_d so the registered outputs line up with the state
    always_comb begin
        coef_ready_d = (state_d == S_LOAD);
        busy_d       = (state_d != S_IDLE);
        load_done_d  = swap_s;
        load_abort_d = load_start && (state_q != S_IDLE);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            coef_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            load_abort_q <= 1'b0;
        end else begin
            coef_ready_q <= coef_ready_d;
            busy_q       <= busy_d;
            load_done_q  <= load_done_d;
            load_abort_q <= load_abort_d;
        end
    end

    // Shadow write, index update and atomic shadow-to-active swap
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= {IDX_W{1'b0}};
            for (int k = 0; k < TAPS; k++) begin
                shadow_q[k] <= {DATA_WIDTH{1'b0}};
                active_q[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            idx_q <= idx_d;
            if (hs_s) begin
                shadow_q[idx_q] <= coef_data;
            end
            if (swap_s) begin
                for (int k = 0; k < TAPS; k++) begin
                    active_q[k] <= shadow_q[k];
                end
            end
        end
    end

    for (genvar g = 0; g < TAPS; g++) begin : g_wn
        assign w_N[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
    end

    assign coef_ready = coef_ready_q;
    assign busy       = busy_q;
    assign load_done  = load_done_q;
    assign load_abort = load_abort_q;

`ifdef FIR_COEF_READBACK_EN
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Registered readback; reads the pre-swap value in the swap cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= {DATA_WIDTH{1'b0}};
        end else if (32'(rd_addr) < 32'(TAPS)) begin
            rd_data_q <= active_q[rd_addr];
        end else begin
            rd_data_q <= {DATA_WIDTH{1'b0}};
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_fir_coef_bank.sv
module tb_fir_coef_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        coef_valid;
    logic [15:0] coef_data;
    logic        coef_ready;
    logic        swap_en;
    logic [63:0] w_N;
    logic        busy;
    logic        load_done;
    logic        load_abort;
`ifdef FIR_COEF_READBACK_EN
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] BANK_B2B  = 64'h0004_0003_0002_0001;
    localparam logic [63:0] BANK_GAPS = 64'h0000_7FFF_8000_FFFF;
    localparam logic [63:0] BANK_ABCD = 64'h000D_000C_000B_000A;

    fir_coef_bank #(.TAPS(4), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef FIR_COEF_READBACK_EN
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
`endif
        .load_start (load_start),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .swap_en    (swap_en),
        .w_N        (w_N),
        .busy       (busy),
        .load_done  (load_done),
        .load_abort (load_abort)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stream four words back-to-back (word k from bits [16k +: 16])
    task automatic drive_words(input logic [63:0] words);
        for (int k = 0; k < 4; k++) begin
            coef_valid = 1'b1;
            coef_data  = words[16*k +: 16];
            step();
        end
        coef_valid = 1'b0;
        coef_data  = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 1'b0; coef_valid = 1'b0; coef_data = 16'h0000; swap_en = 1'b0;
`ifdef FIR_COEF_READBACK_EN
        rd_addr = 2'd0;
`endif
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (w_N !== 64'h0) begin failures++; $display("FAIL reset_wn: got %h expected %h", w_N, 64'h0); end
        checks++; if (coef_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", coef_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (load_done !== 1'b0 || load_abort !== 1'b0) begin
            failures++; $display("FAIL reset_pulses: got done=%b abort=%b expected 0 0", load_done, load_abort);
        end
`ifdef FIR_COEF_READBACK_EN
        checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
`endif
    endtask

    task automatic test_back_to_back();
        int ready_cnt;
        ready_cnt  = 0;
        load_start = 1'b1;
        swap_en    = 1'b1;
        step();
        load_start = 1'b0;
        checks++; if (coef_ready !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL b2b_start_latency: got ready=%b busy=%b expected 1 1", coef_ready, busy);
        end
        for (int k = 0; k < 4; k++) begin
            if (coef_ready === 1'b1) ready_cnt++;
            coef_valid = 1'b1;
            coef_data  = 16'(k + 1);
            step();
        end
        coef_valid = 1'b0;
        if (coef_ready === 1'b1) ready_cnt++;
        checks++; if (coef_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_drop: got %b expected 0", coef_ready); end
        checks++; if (w_N !== 64'h0 || load_done !== 1'b0) begin
            failures++; $display("FAIL b2b_early_swap: got w_N=%h done=%b expected %h 0", w_N, load_done, 64'h0);
        end
        step();
        checks++; if (w_N !== BANK_B2B) begin failures++; $display("FAIL b2b_wn: got %h expected %h", w_N, BANK_B2B); end
        checks++; if (load_done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_done: got done=%b busy=%b expected 1 0", load_done, busy);
        end
        checks++; if (ready_cnt != 4) begin failures++; $display("FAIL b2b_ready_cycles: got %0d expected 4", ready_cnt); end
        step();
        swap_en = 1'b0;
        checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL b2b_done_pulse: got %b expected 0", load_done); end
    endtask

    task automatic test_gaps_held();
        swap_en    = 1'b0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            coef_valid = (i % 2 == 0);
            coef_data  = (i % 2 == 0) ? BANK_GAPS[(i/2)*16 +: 16] : 16'hDEAD;
            step();
        end
        // a word offered while pending must be ignored
        coef_valid = 1'b1;
        coef_data  = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            checks++; if (w_N !== BANK_B2B || busy !== 1'b1 || coef_ready !== 1'b0) begin
                failures++;
                $display("FAIL held_pend[%0d]: got w_N=%h busy=%b ready=%b expected %h 1 0", i, w_N, busy, coef_ready, BANK_B2B);
            end
            step();
        end
        coef_valid = 1'b0;
        swap_en    = 1'b1;
        step();
        swap_en = 1'b0;
        checks++; if (w_N !== BANK_GAPS) begin failures++; $display("FAIL gaps_wn: got %h expected %h", w_N, BANK_GAPS); end
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL gaps_done: got %b expected 1", load_done); end
        step();
        checks++; if (load_done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL gaps_idle: got done=%b busy=%b expected 0 0", load_done, busy);
        end
    endtask

    task automatic test_restart();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        coef_valid = 1'b1; coef_data = 16'h1111; step();
        coef_data  = 16'h2222; step();
        coef_valid = 1'b0;
        load_start = 1'b1;
        checks++; if (load_abort !== 1'b0) begin failures++; $display("FAIL restart_no_early_abort: got %b expected 0", load_abort); end
        step();
        load_start = 1'b0;
        checks++; if (load_abort !== 1'b1 || coef_ready !== 1'b1) begin
            failures++; $display("FAIL restart_load: got abort=%b ready=%b expected 1 1", load_abort, coef_ready);
        end
        checks++; if (w_N !== BANK_GAPS) begin failures++; $display("FAIL restart_active_kept: got %h expected %h", w_N, BANK_GAPS); end
        // restart coincident with the last word: the word is dropped and the FSM stays in LOAD
        coef_valid = 1'b1;
        coef_data = 16'h0001; step();
        checks++; if (load_abort !== 1'b0) begin failures++; $display("FAIL restart_abort_pulse: got %b expected 0", load_abort); end
        coef_data = 16'h0002; step();
        coef_data = 16'h0003; step();
        coef_data = 16'h9999; load_start = 1'b1; step();
        load_start = 1'b0; coef_valid = 1'b0;
        checks++; if (coef_ready !== 1'b1 || load_abort !== 1'b1) begin
            failures++; $display("FAIL restart_coincident_hs: got ready=%b abort=%b expected 1 1", coef_ready, load_abort);
        end
        // restart coincident with swap_en in PEND: no swap
        drive_words(64'h5555_5555_5555_5555);
        checks++; if (coef_ready !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL restart_pend_entry: got ready=%b busy=%b expected 0 1", coef_ready, busy);
        end
        load_start = 1'b1; swap_en = 1'b1; step();
        load_start = 1'b0; swap_en = 1'b0;
        checks++; if (load_done !== 1'b0 || load_abort !== 1'b1) begin
            failures++; $display("FAIL restart_pend_swap: got done=%b abort=%b expected 0 1", load_done, load_abort);
        end
        checks++; if (w_N !== BANK_GAPS) begin failures++; $display("FAIL restart_pend_wn: got %h expected %h", w_N, BANK_GAPS); end
        swap_en = 1'b1;
        drive_words(BANK_ABCD);
        step();
        swap_en = 1'b0;
        checks++; if (w_N !== BANK_ABCD || load_done !== 1'b1) begin
            failures++; $display("FAIL restart_final: got w_N=%h done=%b expected %h 1", w_N, load_done, BANK_ABCD);
        end
    endtask

    task automatic test_reset_pend();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        swap_en    = 1'b0;
        drive_words(64'h0044_0033_0022_0011);
        checks++; if (busy !== 1'b1 || w_N !== BANK_ABCD) begin
            failures++; $display("FAIL rstpend_pending: got busy=%b w_N=%h expected 1 %h", busy, w_N, BANK_ABCD);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (w_N !== 64'h0 || busy !== 1'b0 || coef_ready !== 1'b0) begin
            failures++; $display("FAIL rstpend_reset: got w_N=%h busy=%b ready=%b expected 0 0 0", w_N, busy, coef_ready);
        end
        checks++; if (load_done !== 1'b0 || load_abort !== 1'b0) begin
            failures++; $display("FAIL rstpend_pulses: got done=%b abort=%b expected 0 0", load_done, load_abort);
        end
        swap_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (w_N !== 64'h0 || load_done !== 1'b0) begin
                failures++; $display("FAIL rstpend_late_swap[%0d]: got w_N=%h done=%b expected 0 0", i, w_N, load_done);
            end
        end
        swap_en = 1'b0;
    endtask

`ifdef FIR_COEF_READBACK_EN
    task automatic test_readback();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        swap_en    = 1'b1;
        drive_words(64'h0008_0007_0006_0005);
        step();
        swap_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k);
            step();
            checks++; if (rd_data !== 16'(k + 5)) begin
                failures++; $display("FAIL readback[%0d]: got %h expected %h", k, rd_data, 16'(k + 5));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps_held();
        test_restart();
        test_reset_pend();
`ifdef FIR_COEF_READBACK_EN
        test_readback();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
